// File: rtl/sorter_pkg.sv
// sorter_pkg: shared types and default sizes for the streaming insertion sorter
package sorter_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int N_DEF      = 256;
   typedef enum logic {LOAD, DRAIN} state_e;
   typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/sorter_cell.sv
// sorter_cell: one compare/hold slot of the insertion array; SORTER_DESCEND_EN flips the order
module sorter_cell
   import sorter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
)(
   input  logic              clk,
   input  logic              xrst,
   input  logic [DATA_W-1:0] din,
   input  logic [DATA_W-1:0] prev_v,
   input  logic              prev_occ,
   input  logic              prev_shift,
   input  logic [DATA_W-1:0] next_v,
   input  logic              next_occ,
   input  logic              load_en,
   input  logic              drain_en,
   output logic [DATA_W-1:0] v,
   output logic              occ,
   output logic              shift
);
   logic [DATA_W-1:0] v_q, v_d;
   logic              occ_q, occ_d;
   // An empty cell loses every compare, so new words always land before it
`ifdef SORTER_DESCEND_EN
   assign shift = !occ_q || (din > v_q);
`else
   assign shift = !occ_q || (din < v_q);
`endif
   assign v   = v_q;
   assign occ = occ_q;
   // Drain moves the chain one slot towards cell 0; load inserts or pushes the neighbour down
   always_comb begin
      v_d   = v_q;
      occ_d = occ_q;
      if (drain_en) begin
         v_d   = next_v;
         occ_d = next_occ;
      end else if (load_en && shift) begin
         v_d   = prev_shift ? prev_v : din;
         occ_d = prev_shift ? prev_occ : 1'b1;
      end
   end
   // Slot storage
   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         v_q   <= '0;
         occ_q <= 1'b0;
      end else begin
         v_q   <= v_d;
         occ_q <= occ_d;
      end
   end
endmodule

// File: rtl/sorter.sv
// sorter: streaming batch sorter over a linear insertion array; define SORTER_DESCEND_EN for descending order
module sorter
   import sorter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N      = N_DEF
)(
   input  logic              clk,
   input  logic              xrst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out
);
   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   state_e            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic              load_en, drain_en, last;
   logic [DATA_W-1:0] v_ext [N+2];
   logic [N+1:0]      occ_ext;
   logic [N:0]        sh_ext;
   logic              unused_shift;
   assign load_en      = (state_q == LOAD) && valid_in;
   assign drain_en     = (state_q == DRAIN);
   assign last         = (count_q == LAST);
   assign v_ext[0]     = '0;
   assign v_ext[N+1]   = '0;
   assign occ_ext[0]   = 1'b0;
   assign occ_ext[N+1] = 1'b0;
   assign sh_ext[0]    = 1'b0;
   assign unused_shift = sh_ext[N];
   assign valid_out    = drain_en;
   assign data_out     = drain_en ? v_ext[1] : '0;
   // Padded chain: cell i sits at index i+1, the ends read as empty neighbours
   for (genvar i = 0; i < N; i++) begin : g_cell
      sorter_cell #(.DATA_W(DATA_W)) u_cell (
         .clk       (clk),
         .xrst      (xrst),
         .din       (data_in),
         .prev_v    (v_ext[i]),
         .prev_occ  (occ_ext[i]),
         .prev_shift(sh_ext[i]),
         .next_v    (v_ext[i+2]),
         .next_occ  (occ_ext[i+2]),
         .load_en   (load_en),
         .drain_en  (drain_en),
         .v         (v_ext[i+1]),
         .occ       (occ_ext[i+1]),
         .shift     (sh_ext[i+1])
      );
   end
   // One counter serves both phases: N accepted words, then N emitted words
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (load_en || drain_en) begin
         count_d = last ? '0 : count_q + 1'b1;
         state_d = last ? (drain_en ? LOAD : DRAIN) : state_q;
      end
   end
   // Phase and counter registers
   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         state_q <= LOAD;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_sorter.sv
// tb_sorter: directed frames against a sorted-copy reference of each frame
module tb_sorter;
   import sorter_pkg::*;
   localparam int N = N_DEF;
   logic  clk = 1'b0;
   logic  xrst, valid_in, valid_out;
   word_t data_in, data_out;
   word_t frm [N];
   int    n_chk = 0, n_fail = 0, cyc = 0, c0 = 0;

   sorter #(.DATA_W(DATA_W_DEF), .N(N)) dut (
      .clk      (clk),
      .xrst     (xrst),
      .data_in  (data_in),
      .valid_in (valid_in),
      .data_out (data_out),
      .valid_out(valid_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input bit gapped);
      for (int k = 0; k < N; k++) begin
         data_in  = frm[k];
         valid_in = 1'b1;
         step();
         if (k == 0) c0 = cyc;
         if (k < N - 1) check("load_hold", 32'(valid_out), 0);
         if (gapped && k < N - 1) begin
            valid_in = 1'b0;
            data_in  = ~frm[k];
            step();
            check("gap_hold", 32'(valid_out), 0);
         end
      end
      valid_in = 1'b0;
   endtask

   task automatic drain(input bit poke, input int stop_at);
      word_t q[$];
      for (int k = 0; k < N; k++) q.push_back(frm[k]);
`ifdef SORTER_DESCEND_EN
      q.rsort();
`else
      q.sort();
`endif
      for (int j = 0; j < stop_at; j++) begin
         check("out_valid", 32'(valid_out), 1);
         check("out_data", 32'(data_out), 32'(q[j]));
         if (poke) begin
            valid_in = j[0];
            data_in  = word_t'($urandom);
         end
         step();
      end
      valid_in = 1'b0;
      if (stop_at == N) begin
         check("end_valid", 32'(valid_out), 0);
         check("end_data", 32'(data_out), 0);
      end
   endtask

   initial begin
      xrst     = 1'b1;
      valid_in = 1'b0;
      data_in  = '0;
      #12;
      check("rst_valid", 32'(valid_out), 0);
      check("rst_data", 32'(data_out), 0);
      step();
      xrst = 1'b0;
      step();
      // ramp down 255..0
      for (int k = 0; k < N; k++) frm[k] = word_t'(N - 1 - k);
      load(1'b0);
      check("ramp_first", 32'(data_out), 32'(frm[N-1]));
      drain(1'b0, N);
      check("ramp_cycles", 32'(cyc - c0 + 1), 32'(2 * N));
      // random frame
      for (int k = 0; k < N; k++) frm[k] = word_t'($urandom);
      load(1'b0);
      drain(1'b0, N);
      check("rand_cycles", 32'(cyc - c0 + 1), 32'(2 * N));
      // all equal, then alternating 0/255
      for (int k = 0; k < N; k++) frm[k] = 8'hA5;
      load(1'b0);
      drain(1'b0, N);
      for (int k = 0; k < N; k++) frm[k] = k[0] ? 8'hFF : 8'h00;
      load(1'b0);
      drain(1'b0, N);
      // gapped input with valid_in pulses during drain
      for (int k = 0; k < N; k++) frm[k] = word_t'($urandom);
      load(1'b1);
      drain(1'b1, N);
      // reset after 10 outputs
      for (int k = 0; k < N; k++) frm[k] = word_t'($urandom);
      load(1'b0);
      drain(1'b0, 10);
      #2 xrst = 1'b1;
      #1;
      check("abort_valid", 32'(valid_out), 0);
      check("abort_data", 32'(data_out), 0);
      step();
      xrst = 1'b0;
      step();
      check("post_rst_valid", 32'(valid_out), 0);
      // partial frame waits, then is discarded by reset
      for (int k = 0; k < 5; k++) begin
         data_in  = 8'h00;
         valid_in = 1'b1;
         step();
      end
      valid_in = 1'b0;
      repeat (20) step();
      check("partial_wait", 32'(valid_out), 0);
      xrst = 1'b1;
      step();
      xrst = 1'b0;
      step();
      // fresh frame must show no stale words
      for (int k = 0; k < N; k++) frm[k] = word_t'($urandom_range(1, 255));
      load(1'b0);
      drain(1'b0, N);
      check("fresh_cycles", 32'(cyc - c0 + 1), 32'(2 * N));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
